// File: rtl/mem_burst_sequencer.sv
// Burst request engine in front of a single-beat memory controller.
// Splits a burst command into one we/re pulse per beat, waits for the
// controller's ready between beats (with a per-beat timeout) and returns
// read beats on a valid/ready stream.
module mem_burst_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic                    mem_we,
  output logic                    mem_re,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);
  localparam int BE_WIDTH = DATA_WIDTH/8;
  localparam int CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  // Last wait-counter value before the timeout fires
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WR_DATA, WR_WAIT, RD_REQ, RD_WAIT, RD_OUT, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;          // address of the current beat
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;  // address presented to the controller
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BE_WIDTH-1:0]     be_q, be_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [LEN_WIDTH-1:0]    rem_q, rem_d;            // beats left after the current one
  logic [CNT_W-1:0]        wcnt_q, wcnt_d;
  logic                    first_q, first_d;        // marks the first cycle of a *_WAIT state
  logic                    error_q, error_d;

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      rdata_q    <= '0;
      rem_q      <= '0;
      wcnt_q     <= '0;
      first_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      rdata_q    <= rdata_d;
      rem_q      <= rem_d;
      wcnt_q     <= wcnt_d;
      first_q    <= first_d;
      error_q    <= error_d;
    end
  end

  // Next-state and datapath updates; mem_ready only matters in the wait states
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    rdata_d    = rdata_q;
    rem_d      = rem_q;
    wcnt_d     = wcnt_q;
    first_d    = 1'b0;
    error_d    = error_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          error_d = 1'b0;
          state_d = cmd_write ? WR_DATA : RD_REQ;
        end
      end
      WR_DATA: begin
        if (wr_valid) begin
          mem_addr_d = addr_q;
          wdata_d    = wr_data;
          be_d       = wr_be;
          wcnt_d     = '0;
          first_d    = 1'b1;
          state_d    = WR_WAIT;
        end
      end
      RD_REQ: begin
        mem_addr_d = addr_q;
        wcnt_d     = '0;
        first_d    = 1'b1;
        state_d    = RD_WAIT;
      end
      WR_WAIT, RD_WAIT: begin
        if (mem_ready) begin
          if (state_q == RD_WAIT) begin
            rdata_d = mem_rdata;
            state_d = RD_OUT;
          end else if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            rem_d   = rem_q - LEN_ONE;
            state_d = WR_DATA;
          end
        end else if (wcnt_q == CNT_LAST) begin
          // Controller stalled: drop the rest of the burst
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wcnt_d = wcnt_q + CNT_ONE;
        end
      end
      RD_OUT: begin
        if (rd_ready) begin
          if (rem_q == '0) begin
            state_d = DONE;
          end else begin
            addr_d  = addr_q + ADDR_ONE;
            rem_d   = rem_q - LEN_ONE;
            state_d = RD_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign wr_ready  = (state_q == WR_DATA);
  assign rd_valid  = (state_q == RD_OUT);
  assign rd_data   = rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign mem_we    = (state_q == WR_WAIT) && first_q;
  assign mem_re    = (state_q == RD_WAIT) && first_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign error     = error_q;

endmodule

// File: tb/tb_mem_burst_sequencer.sv
// Bench for mem_burst_sequencer: emulated single-beat controller plus a
// flat reference memory predicting every beat address, data and read value.
module tb_mem_burst_sequencer;
  localparam int AW = 16, DW = 32, LW = 8, TO = 15, BW = DW/8;

  logic          clk = 1'b0, reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0, wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic [BW-1:0] wr_be = '0;
  logic          rd_valid, rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy, done, error;

  always #5 clk = ~clk;

  mem_burst_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .done(done), .error(error)
  );

  int errs = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  // Emulated controller: answers each pulse after 1+extra cycles unless stalled
  logic [DW-1:0] ctrl_mem [65536];
  bit            ctrl_wr  [65536];
  bit            stall = 1'b0;
  int            extra = 0, dly = 0;
  logic          pend = 1'b0;

  function automatic logic [DW-1:0] crd(input logic [AW-1:0] a);
    return ctrl_wr[a] ? ctrl_mem[a] : dflt(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0; pend <= 1'b0; dly <= 0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_we) begin
        ctrl_mem[mem_addr] <= merge(crd(mem_addr), mem_wdata, mem_be);
        ctrl_wr[mem_addr]  <= 1'b1;
      end
      if (mem_re) mem_rdata <= crd(mem_addr);
      if ((mem_we || mem_re) && !stall) begin
        if (extra == 0) mem_ready <= 1'b1;
        else begin pend <= 1'b1; dly <= extra - 1; end
      end else if (pend) begin
        if (dly == 0) begin mem_ready <= 1'b1; pend <= 1'b0; end
        else dly <= dly - 1;
      end
    end
  end

  // Reference memory: what the controller should hold after each burst
  logic [DW-1:0] ref_mem [65536];

  // One burst. tim=1: directed (data base+i, be all ones, valid/ready held high,
  // zero controller delay) with latency checks; tim=0: randomized handshakes.
  task automatic burst(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] len,
                       input bit stl, input int hold, input bit tim, input logic [DW-1:0] base);
    logic [DW-1:0] wd[$];
    logic [BW-1:0] wb[$];
    logic [AW-1:0] ea;
    int nb, npulse, wi, ri, nwe, nre, hs_cyc, last_re, last_pulse, hold_left;
    bit fin;
    nb = int'(len) + 1; npulse = stl ? 1 : nb;
    wi = 0; ri = 0; nwe = 0; nre = 0; hs_cyc = -1; last_re = -1; last_pulse = -1;
    hold_left = hold; fin = 1'b0;
    stall = stl;
    extra = tim ? 0 : int'($urandom_range(0, 4));
    for (int i = 0; i < nb; i++) begin
      wd.push_back(tim ? base + DW'(i) : DW'($urandom));
      wb.push_back(tim ? {BW{1'b1}} : BW'($urandom_range(1, 15)));
    end
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = $urandom;
    chk("err_cleared", error, 0);
    for (int c = 0; c < nb * 40 + 60 && !fin; c++) begin
      if (mem_we || mem_re) chk("we_re_excl", mem_we & mem_re, 0);
      if (mem_we) begin
        chk("we_count_ok", nwe < nb, 1);
        if (nwe < nb) begin
          ea = a + AW'(nwe);
          chk("we_addr", mem_addr, ea);
          chk("we_data", mem_wdata, wd[nwe]);
          chk("we_be", mem_be, wb[nwe]);
        end
        if (tim) chk("we_latency", cyc - hs_cyc, 1);
        last_pulse = cyc; nwe++;
      end
      if (mem_re) begin
        ea = a + AW'(nre);
        chk("re_addr", mem_addr, ea);
        if (tim && hold == 0 && last_re >= 0) chk("re_spacing", cyc - last_re, 4);
        last_re = cyc; last_pulse = cyc; nre++;
      end
      // write data stream
      if (wr_ready) begin
        if (tim && hs_cyc >= 0) chk("wr_ready_latency", cyc - hs_cyc, 3);
        wr_valid = tim ? 1'b1 : 1'(($urandom_range(0, 1)));
      end else begin
        wr_valid = 1'(($urandom_range(0, 1)));
      end
      if (wr_valid && wr_ready && wi < nb) begin
        wr_data = wd[wi]; wr_be = wb[wi]; hs_cyc = cyc; wi++;
      end else begin
        wr_data = $urandom; wr_be = BW'($urandom);
      end
      // read data stream
      if (rd_valid) begin
        ea = a + AW'(ri);
        if (hold_left > 0) begin
          chk("rd_data_held", rd_data, ref_mem[ea]);
          chk("no_re_while_held", nre, ri + 1);
          rd_ready = 1'b0; hold_left--;
        end else begin
          rd_ready = tim ? 1'b1 : 1'(($urandom_range(0, 1)));
        end
        if (rd_ready) begin
          chk("rd_data", rd_data, ref_mem[ea]);
          ri++;
        end
      end else begin
        rd_ready = tim ? 1'b1 : 1'(($urandom_range(0, 1)));
      end
      if (done) begin
        fin = 1'b1;
        chk("error_at_done", error, stl);
        chk("busy_at_done", busy, 1);
        if (stl) chk("timeout_cycles", cyc - last_pulse, TO);
      end
      @(negedge clk);
    end
    chk("done_seen", fin, 1);
    chk("idle_after_done", cmd_ready, 1);
    chk("done_single_pulse", done, 0);
    chk("we_total", nwe, wr ? npulse : 0);
    chk("re_total", nre, wr ? 0 : npulse);
    chk("rd_total", ri, (wr || stl) ? 0 : nb);
    if (wr) for (int i = 0; i < npulse; i++) begin
      ea = a + AW'(i);
      ref_mem[ea] = merge(ref_mem[ea], wd[i], wb[i]);
    end
    wr_valid = 1'b0; rd_ready = 1'b0; stall = 1'b0;
  endtask

  // Reset while beat 2 of a 3-beat write is waiting for ready
  task automatic reset_mid();
    int n;
    n = 0;
    extra = 0; stall = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0200; cmd_len = 8'd2;
    wr_valid = 1'b1; wr_data = 32'hC0DE_0000; wr_be = '1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 100 && n < 2; c++) begin
      if (mem_we) n++;
      if (n < 2) @(negedge clk);
    end
    chk("rst_reached_beat2", n, 2);
    reset = 1'b1;
    #1;
    chk("rst_mid_flags", {cmd_ready, busy, done, error, mem_we, mem_re, wr_ready, rd_valid}, 8'b1000_0000);
    chk("rst_mid_addr", mem_addr, 0);
    chk("rst_mid_wdata", mem_wdata, 0);
    @(negedge clk);
    chk("rst_no_done", done, 0);
    reset = 1'b0; wr_valid = 1'b0;
    ref_mem[16'h0200] = 32'hC0DE_0000;  // beat 2 pulse never reached the controller
    burst(1'b1, 16'h0201, 8'd0, 1'b0, 0, 1'b1, 32'hD0);
    burst(1'b0, 16'h0200, 8'd1, 1'b0, 0, 1'b1, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = dflt(AW'(i));
    repeat (3) @(negedge clk);
    chk("reset_flags", {cmd_ready, busy, done, error, mem_we, mem_re, wr_ready, rd_valid}, 8'b1000_0000);
    chk("reset_addr", mem_addr, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b0;
    // directed scenarios
    burst(1'b1, 16'h0010, 8'd3, 1'b0, 0, 1'b1, 32'hA0);
    burst(1'b0, 16'h0010, 8'd2, 1'b0, 0, 1'b1, 32'h0);
    burst(1'b0, 16'hFFFF, 8'd1, 1'b0, 0, 1'b1, 32'h0);
    burst(1'b0, 16'h0020, 8'd1, 1'b0, 10, 1'b1, 32'h0);
    burst(1'b1, 16'h0030, 8'd3, 1'b1, 0, 1'b1, 32'hB0);
    burst(1'b1, 16'h0030, 8'd0, 1'b0, 0, 1'b1, 32'hB8);
    burst(1'b0, 16'h0040, 8'd3, 1'b1, 0, 1'b1, 32'h0);
    reset_mid();
    burst(1'b1, 16'hFF80, 8'd255, 1'b0, 0, 1'b1, 32'h1000);
    burst(1'b0, 16'hFFFE, 8'd3, 1'b0, 0, 1'b1, 32'h0);
    // randomized bursts around a small address window and the wrap point
    for (int k = 0; k < 40; k++) begin
      logic [AW-1:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? AW'(16'hFFFC + $urandom_range(0, 3))
                                       : AW'($urandom_range(0, 63));
      burst(1'(($urandom_range(0, 1))), ra, LW'($urandom_range(0, 7)),
            $urandom_range(0, 9) == 0, 0, 1'b0, 32'h0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
